// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier, restoring divider, valid/ready in and out.
// Optional build macro MDU_FAST_MUL_EN replaces the iterative multiplier with a single-cycle one.
module mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    // Applies result signs and word narrowing to the raw {hi, lo} core output.
    // For multiplies {hi, lo} is the product; for divides hi is the remainder, lo the quotient.
    function automatic logic [XLEN-1:0] finalize(
        input logic [2:0]      f_op,
        input logic            f_word,
        input logic            f_neg,
        input logic            f_rneg,
        input logic [XLEN-1:0] f_hi,
        input logic [XLEN-1:0] f_lo
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        logic [XLEN-1:0]   res;
        prod = f_neg ? -{f_hi, f_lo} : {f_hi, f_lo};
        quo  = f_neg ? -f_lo : f_lo;
        rem  = f_rneg ? -f_hi : f_hi;
        case (f_op)
            OP_MUL:                       res = f_word ? sext32(prod[XLEN-1 -: 32]) : prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              res = f_word ? sext32(quo[31:0]) : quo;
            default:                      res = f_word ? sext32(rem[31:0]) : rem;
        endcase
        return res;
    endfunction

    state_t state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            quick_q;
    logic [2:0]      op_q;
    logic            word_q;
    logic            neg_q;
    logic            rneg_q;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] mcand;

    // Operand preparation, evaluated on the request inputs
    logic                   word_eff;
    logic                   sgn1, sgn2;
    logic signed [XLEN-1:0] a_ext, b_ext;
    logic signed [XLEN-1:0] min_neg;
    logic                   s1, s2;
    logic [XLEN-1:0]        mag_a, mag_b;
    logic [XLEN-1:0]        dividend_res;
    logic                   div_zero, ovf, special;
    logic [XLEN-1:0]        special_val;
    logic                   quick;
    logic [XLEN-1:0]        quick_val;
    logic [CW-1:0]          n_acc;
    logic                   accept;

    always_comb begin
        word_eff = is_word && (op == OP_MUL || op[2]);
        sgn1     = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        sgn2     = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_ext    = word_eff ? (sgn1 ? sext32(src1[31:0]) : zext32(src1[31:0])) : src1;
        b_ext    = word_eff ? (sgn2 ? sext32(src2[31:0]) : zext32(src2[31:0])) : src2;
        s1       = sgn1 && a_ext[XLEN-1];
        s2       = sgn2 && b_ext[XLEN-1];
        mag_a    = s1 ? -a_ext : a_ext;
        mag_b    = s2 ? -b_ext : b_ext;
        min_neg  = word_eff ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = op[2] && (b_ext == '0);
        ovf      = (op == OP_DIV || op == OP_REM) && (b_ext == '1) && (a_ext == min_neg);
        special  = div_zero || ovf;
        dividend_res = word_eff ? sext32(src1[31:0]) : src1;
        if (div_zero) begin
            special_val = op[1] ? dividend_res : '1;
        end else begin
            special_val = op[1] ? '0 : dividend_res;
        end
        n_acc = word_eff ? CW'(32) : CW'(XLEN);
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [2*XLEN-1:0] fast_al;
    logic [XLEN-1:0]   fast_val;

    // Word multiplies are shifted so their low 32 bits sit where the iterative core leaves them
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fast_al   = word_eff ? (fast_prod << (XLEN - 32)) : fast_prod;
    assign fast_val  = finalize(op, word_eff, s1 ^ s2, s1, fast_al[2*XLEN-1:XLEN], fast_al[XLEN-1:0]);
    assign quick     = special || !op[2];
    assign quick_val = op[2] ? special_val : fast_val;
`else
    assign quick     = special;
    assign quick_val = special_val;
`endif

    assign accept    = (state == IDLE) && in_valid && !flush;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One iteration step of either core
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_rr, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [XLEN-1:0] done_val;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_rr   = {acc_hi, acc_lo[XLEN-1]};
        div_diff = div_rr - {1'b0, mcand};
        div_ge   = !div_diff[XLEN];
        if (state == MUL) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_rr[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], div_ge};
        end
        done_val = quick_q ? acc_lo : finalize(op_q, word_q, neg_q, rneg_q, step_hi, step_lo);
    end

    // Single-cycle results (special divides, fast multiplies) wait one cycle in DIV with cnt = 1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_nxt = (quick || op[2]) ? DIV : MUL;
                        cnt_nxt   = quick ? CW'(1) : n_acc;
                    end
                end
                MUL, DIV: begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) state_nxt = DONE;
                end
                DONE: begin
                    if (out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            quick_q <= 1'b0;
            result  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) quick_q <= quick;
            if (state != DONE && state_nxt == DONE) result <= done_val;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            op_q   <= op;
            word_q <= word_eff;
            neg_q  <= s1 ^ s2;
            rneg_q <= s1;
            acc_hi <= '0;
            if (quick) begin
                acc_lo <= quick_val;
                mcand  <= '0;
            end else if (op[2]) begin
                // Dividend is MSB-aligned so both widths shift out from bit XLEN-1
                acc_lo <= word_eff ? (mag_a << (XLEN - 32)) : mag_a;
                mcand  <= mag_b;
            end else begin
                acc_lo <= mag_b;
                mcand  <= mag_a;
            end
        end else if ((state == MUL || state == DIV) && !quick_q) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

endmodule
